// File: rtl/run_sequencer_pkg.sv
// Shared definitions for the run sequencer: FSM state encoding and default
// parameter values so the top level and its benches agree.
package run_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        DRAIN,
        RUN,
        NEXT,
        FINISH
    } run_state_t;

    localparam int unsigned DEF_REQ_CYCLES = 4;
    localparam int unsigned DEF_CNT_BITS   = 16;
    localparam int unsigned DEF_TIMEOUT    = 50000;
    localparam int unsigned DEF_PROG_BITS  = 2;

endpackage

// File: rtl/run_sequencer_if.sv
// Host/processor handshake bundle for the run sequencer. The sequencer takes
// the master side; the host and processor model drive the slave side.
interface run_sequencer_if
    import run_sequencer_pkg::*;
#(
    parameter int unsigned PROG_BITS = DEF_PROG_BITS,
    parameter int unsigned CNT_BITS  = DEF_CNT_BITS
);
    logic                 launch;
    logic [PROG_BITS-1:0] prog_count;
    logic                 ack;
    logic                 req;
    logic [PROG_BITS-1:0] prog_sel;
    logic                 busy;
    logic [CNT_BITS-1:0]  cycle_count;
    logic                 count_valid;
    logic                 timeout_err;
    logic                 done;

    modport master (
        input  launch, prog_count, ack,
        output req, prog_sel, busy, cycle_count, count_valid, timeout_err, done
    );

    modport slave (
        output launch, prog_count, ack,
        input  req, prog_sel, busy, cycle_count, count_valid, timeout_err, done
    );
endinterface

// File: rtl/run_sequencer_edge_detect_rise.sv
// Registers a level input and flags the cycle in which it first goes high.
module edge_detect_rise (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic rise
);
    logic level_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;
endmodule

// File: rtl/run_sequencer.sv
// Host-side initiator for the processor req/ack run handshake: launches a
// sequence of programs, measures each run length and flags runs that hang.
module run_sequencer
    import run_sequencer_pkg::*;
#(
    parameter int unsigned REQ_CYCLES = DEF_REQ_CYCLES,
    parameter int unsigned CNT_BITS   = DEF_CNT_BITS,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
    parameter int unsigned PROG_BITS  = DEF_PROG_BITS
) (
    input logic            clock,
    input logic            reset,
    run_sequencer_if.master bus
);
    localparam int unsigned HOLD_BITS = $clog2(REQ_CYCLES + 1);
    localparam logic [HOLD_BITS-1:0] HOLD_LAST = HOLD_BITS'(REQ_CYCLES - 1);
    localparam logic [CNT_BITS-1:0]  WAIT_LAST = CNT_BITS'(TIMEOUT - 1);

    run_state_t           state, state_nx;
    logic [HOLD_BITS-1:0] hold_cnt, hold_cnt_nx;
    logic [CNT_BITS-1:0]  wait_cnt, wait_cnt_nx;
    logic [CNT_BITS-1:0]  cycle_count, cycle_count_nx;
    logic [PROG_BITS-1:0] last_prog, last_prog_nx;
    logic [PROG_BITS-1:0] prog_sel, prog_sel_nx;
    logic                 req, req_nx;
    logic                 busy, busy_nx;
    logic                 count_valid, count_valid_nx;
    logic                 timeout_err, timeout_err_nx;
    logic                 done, done_nx;
    logic                 ack_rise;
    logic [CNT_BITS-1:0]  wait_step;

    edge_detect_rise ack_edge (
        .clock (clock),
        .reset (reset),
        .level (bus.ack),
        .rise  (ack_rise)
    );

    // Saturate rather than wrap so a stuck counter can never alias a short run.
    assign wait_step = (wait_cnt == WAIT_LAST) ? wait_cnt : wait_cnt + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            wait_cnt    <= '0;
            cycle_count <= '0;
            last_prog   <= '0;
            prog_sel    <= '0;
            req         <= 1'b0;
            busy        <= 1'b0;
            count_valid <= 1'b0;
            timeout_err <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nx;
            hold_cnt    <= hold_cnt_nx;
            wait_cnt    <= wait_cnt_nx;
            cycle_count <= cycle_count_nx;
            last_prog   <= last_prog_nx;
            prog_sel    <= prog_sel_nx;
            req         <= req_nx;
            busy        <= busy_nx;
            count_valid <= count_valid_nx;
            timeout_err <= timeout_err_nx;
            done        <= done_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        hold_cnt_nx    = hold_cnt;
        wait_cnt_nx    = wait_cnt;
        cycle_count_nx = cycle_count;
        last_prog_nx   = last_prog;
        prog_sel_nx    = prog_sel;
        busy_nx        = busy;
        count_valid_nx = 1'b0;
        timeout_err_nx = timeout_err;
        done_nx        = 1'b0;

        case (state)
            IDLE: begin
                if (bus.launch) begin
                    last_prog_nx   = bus.prog_count;
                    prog_sel_nx    = '0;
                    busy_nx        = 1'b1;
                    timeout_err_nx = 1'b0;
                    hold_cnt_nx    = '0;
                    state_nx       = REQ;
                end
            end
            REQ: begin
                if (hold_cnt == HOLD_LAST) begin
                    wait_cnt_nx = '0;
                    state_nx    = DRAIN;
                end else begin
                    hold_cnt_nx = hold_cnt + 1'b1;
                end
            end
            DRAIN, RUN: begin
                wait_cnt_nx = wait_step;
                // A completing ack on the last allowed cycle beats the timeout.
                if (state == RUN && ack_rise) begin
                    cycle_count_nx = wait_cnt + 1'b1;
                    count_valid_nx = 1'b1;
                    state_nx       = NEXT;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_err_nx = 1'b1;
                    cycle_count_nx = '1;
                    count_valid_nx = 1'b1;
                    state_nx       = FINISH;
                end else if (state == DRAIN && !bus.ack) begin
                    state_nx = RUN;
                end
            end
            NEXT: begin
                if (prog_sel == last_prog) begin
                    state_nx = FINISH;
                end else begin
                    prog_sel_nx = prog_sel + 1'b1;
                    hold_cnt_nx = '0;
                    state_nx    = REQ;
                end
            end
            FINISH: begin
                done_nx  = 1'b1;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        req_nx = (state_nx == REQ);
    end

    assign bus.req         = req;
    assign bus.prog_sel    = prog_sel;
    assign bus.busy        = busy;
    assign bus.cycle_count = cycle_count;
    assign bus.count_valid = count_valid;
    assign bus.timeout_err = timeout_err;
    assign bus.done        = done;
endmodule

// File: tb/tb_run_sequencer.sv
// Scoreboard bench for run_sequencer: stimulus pushes expected run results,
// a negedge monitor pops and compares on count_valid and done.
module tb_run_sequencer;
    import run_sequencer_pkg::*;

    localparam int unsigned TB_TIMEOUT = 100;
    localparam int unsigned CNT        = 16;
    localparam int unsigned PB         = 2;
    localparam int unsigned RC         = DEF_REQ_CYCLES;

    typedef struct {
        logic [15:0] count;
        logic [1:0]  prog;
        logic        tmo;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    run_sequencer_if #(.PROG_BITS(PB), .CNT_BITS(CNT)) bus ();

    run_sequencer #(
        .REQ_CYCLES (RC),
        .CNT_BITS   (CNT),
        .TIMEOUT    (TB_TIMEOUT),
        .PROG_BITS  (PB)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    exp_t exp_q[$];
    bit   done_exp_q[$];
    int   checks    = 0;
    int   fails     = 0;
    int   cyc       = 0;
    int   last_cv   = -100;
    int   done_seen = 0;
    int   req_hi    = 0;
    exp_t mon_e;
    bit   mon_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: all output checks that depend on DUT timing happen here.
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            req_hi = 0;
        end else begin
            if (bus.count_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected count_valid", bus.count_valid, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("cycle_count", bus.cycle_count, mon_e.count);
                    check("prog_sel at count", bus.prog_sel, mon_e.prog);
                    check("timeout_err at count", bus.timeout_err, mon_e.tmo);
                    check("busy at count", bus.busy, 1);
                end
                last_cv = cyc;
            end
            if (bus.done) begin
                if (done_exp_q.size() == 0) begin
                    check("unexpected done", bus.done, 0);
                end else begin
                    mon_t = done_exp_q.pop_front();
                    check("count_valid to done gap", cyc - last_cv, mon_t ? 1 : 2);
                    check("busy at done", bus.busy, 0);
                    check("timeout_err at done", bus.timeout_err, mon_t);
                end
                done_seen++;
            end
            if (bus.req) begin
                req_hi++;
            end else if (req_hi != 0) begin
                check("req width", req_hi, RC);
                req_hi = 0;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_req(input logic lvl, input string name);
        int n = 0;
        while (bus.req !== lvl && n < 300) begin
            step();
            n++;
        end
        check(name, bus.req, lvl);
    endtask

    task automatic wait_done();
        int start = done_seen;
        int n = 0;
        while (done_seen == start && n < 300) begin
            step();
            n++;
        end
        check("done arrives", (done_seen != start), 1);
    endtask

    task automatic do_launch(input logic [1:0] pc, input bit push_done, input bit tmo);
        if (push_done) done_exp_q.push_back(tmo);
        bus.prog_count = pc;
        bus.launch     = 1'b1;
        step();
        bus.launch     = 1'b0;
        check("req after launch", bus.req, 1);
        check("busy after launch", bus.busy, 1);
        check("prog_sel after launch", bus.prog_sel, 0);
        check("timeout_err cleared", bus.timeout_err, 0);
    endtask

    // s cycles of stale-high ack after req falls, l low cycles, then ack rises.
    task automatic do_run(input int s, input int l, input int pulse_at, input logic [1:0] prog);
        exp_t e;
        e.count = 16'(s + l + 1);
        e.prog  = prog;
        e.tmo   = 1'b0;
        exp_q.push_back(e);
        wait_req(1'b1, "req rise");
        wait_req(1'b0, "req fall");
        for (int i = 0; i < s; i++) begin
            bus.ack = 1'b1;
            step();
        end
        for (int i = 0; i < l; i++) begin
            bus.ack    = 1'b0;
            bus.launch = (i == pulse_at);
            if (i == pulse_at) bus.prog_count = 2'd3;
            step();
            if (i == pulse_at) begin
                bus.launch = 1'b0;
                check("prog_sel after busy launch", bus.prog_sel, prog);
            end
        end
        bus.ack = 1'b1;
    endtask

    initial begin
        exp_t e;
        bus.launch     = 1'b0;
        bus.prog_count = '0;
        bus.ack        = 1'b0;
        repeat (3) step();
        check("reset req", bus.req, 0);
        check("reset prog_sel", bus.prog_sel, 0);
        check("reset busy", bus.busy, 0);
        check("reset cycle_count", bus.cycle_count, 0);
        check("reset count_valid", bus.count_valid, 0);
        check("reset timeout_err", bus.timeout_err, 0);
        check("reset done", bus.done, 0);
        reset = 1'b0;
        step();

        do_launch(2'd0, 1, 0);
        do_run(0, 19, -1, 2'd0);
        wait_done();

        do_launch(2'd0, 1, 0);
        do_run(3, 10, -1, 2'd0);
        wait_done();

        do_launch(2'd2, 1, 0);
        do_run(0, 4, -1, 2'd0);
        do_run(0, 6, -1, 2'd1);
        do_run(0, 8, -1, 2'd2);
        wait_done();

        do_launch(2'd0, 1, 0);
        do_run(0, TB_TIMEOUT - 1, -1, 2'd0);
        wait_done();

        e.count = 16'hFFFF;
        e.prog  = 2'd0;
        e.tmo   = 1'b1;
        exp_q.push_back(e);
        do_launch(2'd0, 1, 1);
        wait_req(1'b0, "req fall timeout");
        bus.ack = 1'b0;
        wait_done();
        step();
        check("timeout_err sticky", bus.timeout_err, 1);
        do_launch(2'd0, 1, 0);
        do_run(0, 2, -1, 2'd0);
        wait_done();

        do_launch(2'd0, 0, 0);
        wait_req(1'b0, "req fall reset run");
        bus.ack = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        check("reset mid-run req", bus.req, 0);
        check("reset mid-run busy", bus.busy, 0);
        check("reset mid-run count_valid", bus.count_valid, 0);
        check("reset mid-run done", bus.done, 0);
        reset = 1'b0;
        step();
        do_launch(2'd1, 1, 0);
        do_run(0, 3, -1, 2'd0);
        do_run(0, 2, -1, 2'd1);
        wait_done();

        do_launch(2'd0, 1, 0);
        do_run(0, 10, 4, 2'd0);
        wait_done();
        repeat (10) step();
        check("pending results", exp_q.size(), 0);
        check("pending dones", done_exp_q.size(), 0);
        check("idle after all", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Host-side initiator for the processor's req/ack run handshake; the processor top level is the responder.
- Launches one or more program runs back to back by driving req and selecting the program index.
- Waits for ack on each run, measures run length in clock cycles, and flags runs that never finish.
- Sits between the testbench/host and the processor top level, in the same clock domain.

Parameters:
- REQ_CYCLES, 4, clock cycles req is held high per launch. Must cover at least one divided-clock edge of the PC.
- CNT_BITS, 16, width of the cycle counter and timeout compare.
- TIMEOUT, 16'd50000, cycles to wait for ack before declaring a timeout.
- PROG_BITS, 2, width of the program index.

Ports:
- clock  in  1  system clock; the same clock fed to the processor top level.
- reset  in  1  synchronous, active-high.
- launch  in  1  host start pulse; sampled only in IDLE.
- prog_count  in  PROG_BITS  number of programs to run, minus 1. Runs go 0..prog_count.
- ack  in  1  processor finished flag; level, may stay high for many cycles.
- req  out  1  processor start request.
- prog_sel  out  PROG_BITS  index of the current program.
- busy  out  1  high from launch acceptance until done.
- cycle_count  out  CNT_BITS  measured length of the last run.
- count_valid  out  1  one-cycle pulse when cycle_count updates.
- timeout_err  out  1  sticky; cleared on the next accepted launch or on reset.
- done  out  1  one-cycle pulse after the final run or after a timeout.

Behaviour:
- Reset values:
  - req=0, prog_sel=0, busy=0, cycle_count=0.
  - count_valid=0, timeout_err=0, done=0.
  - state=IDLE, internal counters=0.
  - Reset mid-run aborts immediately: req drops the next cycle, and no done pulse is issued.
- IDLE:
  - launch=1: latch prog_count into last_prog, set prog_sel=0, busy=1, timeout_err=0, go to REQ.
  - launch is ignored in all other states.
- REQ:
  - req=1 for exactly REQ_CYCLES cycles; hold_cnt counts 0..REQ_CYCLES-1.
  - Then req=0, wait_cnt=0, go to DRAIN.
- DRAIN:
  - A stale ack from the previous program may still be high. Stay here until ack=0.
  - wait_cnt increments every cycle.
  - On ack=0, go to RUN.
- RUN:
  - wait_cnt increments every cycle.
  - On ack=1 with the previous-cycle ack=0 (rising edge, registered ack_q): cycle_count=wait_cnt+1, count_valid pulses, go to NEXT.
- Timeout:
  - In DRAIN or RUN, when wait_cnt==TIMEOUT-1 and no qualifying ack edge: timeout_err=1, cycle_count=all ones, count_valid pulses, go to FINISH.
  - A qualifying ack in that same cycle wins over the timeout.
- NEXT:
  - If prog_sel==last_prog, go to FINISH.
  - Otherwise prog_sel increments (no wrap; last_prog bounds it) and go to REQ.
  - prog_sel changes only in NEXT and IDLE, so it is stable for the whole run.
- FINISH:
  - done=1 for one cycle, busy=0, go to IDLE. prog_sel holds its last value.
- Latency:
  - launch to req rise is 1 cycle.
  - ack rising edge to count_valid is 1 cycle (ack is registered).
  - Final count_valid to done is 2 cycles.
- Width rules:
  - wait_cnt saturates at TIMEOUT-1 and never wraps; TIMEOUT must be below 2^CNT_BITS.
  - cycle_count counts cycles from the req fall to the ack rise, inclusive of the ack cycle.
- ack already low with no stale level: DRAIN lasts 1 cycle and is included in the count.

Decomposition:
- Shared package (definitions):
  - run_state_t enum: IDLE, REQ, DRAIN, RUN, NEXT, FINISH.
  - Default REQ_CYCLES and TIMEOUT constants, so the top level and benches agree.
- One sub-module: edge_detect_rise (registered input, rise pulse out), reusable for other level handshakes.
- All other logic stays flat in run_sequencer.

Test Plan:
- Single run: launch with prog_count=0, ack rises 20 cycles after req falls -> req high 4 cycles, cycle_count=20, count_valid pulse, done 2 cycles later, busy low.
- Stale ack: ack held high during REQ and for 3 cycles after -> no early completion; ack then rises again after 10 more cycles -> cycle_count=14.
- Multi-program: prog_count=2, each ack after 5/7/9 cycles -> prog_sel 0,1,2 in turn, three count_valid pulses with 5, 7, 9, a single done.
- Timeout: TIMEOUT=100, ack never rises -> at cycle 100, timeout_err=1, cycle_count=16'hFFFF, done; next launch clears timeout_err.
- Reset mid-RUN: reset asserted 3 cycles into RUN -> next cycle req=0, busy=0, state IDLE, no done; a new launch runs normally.
- Launch while busy: pulse launch during RUN -> ignored, prog_sel unchanged, one done only.
